// File: rtl/arm_mem_responder_if.sv
// Core-side memory bus between the ARM core and arm_mem_responder.
// Groups the fetch channel, the data load/store channel and the shared error flag.
// master: the core drives requests, addresses and store data.
// slave:  the responder drives the instruction word, load data, pulses and error.
interface arm_mem_responder_if;
    logic        fetch_req;
    logic [31:0] inst_addr;
    logic [31:0] inst;
    logic        inst_valid;
    logic        mem_req;
    logic        mem_write_en;
    logic [31:0] mem_addr;
    logic [31:0] mem_data_in;
    logic [31:0] mem_data_out;
    logic        mem_ack;
    logic        mem_err;

    modport master (
        output fetch_req, inst_addr,
        output mem_req, mem_write_en, mem_addr, mem_data_in,
        input  inst, inst_valid,
        input  mem_data_out, mem_ack, mem_err
    );

    modport slave (
        input  fetch_req, inst_addr,
        input  mem_req, mem_write_en, mem_addr, mem_data_in,
        output inst, inst_valid,
        output mem_data_out, mem_ack, mem_err
    );
endinterface

// File: rtl/arm_mem_responder.sv
// arm_mem_responder: single-ported word memory serving one fetch or data access
// at a time, with per-port latency, one-cycle completion pulses and error flag.
// Ports: clk, rst (sync, active-high), halted (blocks new requests),
//   load_en/load_addr/load_data (backdoor preload, IDLE only),
//   bus (arm_mem_responder_if.slave: fetch and data channels, all outputs registered).
module arm_mem_responder #(
    parameter int ADDR_WIDTH    = 10,
    parameter int FETCH_LATENCY = 1,
    parameter int DATA_LATENCY  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  halted,
    input  logic                  load_en,
    input  logic [ADDR_WIDTH-1:0] load_addr,
    input  logic [31:0]           load_data,
    arm_mem_responder_if.slave    bus
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        FETCH_BUSY,
        DATA_BUSY
    } state_t;

    logic [31:0] mem [DEPTH];

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       addr_q, addr_d;
    logic              we_q, we_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       inst_q, inst_d;
    logic              inst_valid_q, inst_valid_d;
    logic [31:0]       mem_data_out_q, mem_data_out_d;
    logic              mem_ack_q, mem_ack_d;
    logic              mem_err_q, mem_err_d;

    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_waddr;
    logic [31:0]           mem_wdata;
    logic [ADDR_WIDTH-1:0] idx;
    logic                  addr_ok;
    logic [31:0]           rd_data;
    logic                  accept_ok;
    logic                  cnt_done;

    // Checks apply to the latched address; the index is only meaningful when addr_ok.
    assign idx       = addr_q[ADDR_WIDTH+1:2];
    assign addr_ok   = (addr_q[1:0] == 2'b00) && ((addr_q >> (ADDR_WIDTH + 2)) == 32'd0);
    assign rd_data   = mem[idx];
    assign accept_ok = !load_en && !halted;
    assign cnt_done  = (cnt_q == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (accept_ok && bus.mem_req) begin
                    state_d = DATA_BUSY;
                end else if (accept_ok && bus.fetch_req) begin
                    state_d = FETCH_BUSY;
                end
            end
            FETCH_BUSY, DATA_BUSY: begin
                if (cnt_done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d          = cnt_q;
        addr_d         = addr_q;
        we_d           = we_q;
        wdata_d        = wdata_q;
        inst_d         = inst_q;
        inst_valid_d   = 1'b0;
        mem_data_out_d = mem_data_out_q;
        mem_ack_d      = 1'b0;
        mem_err_d      = 1'b0;
        mem_we         = 1'b0;
        mem_waddr      = load_addr;
        mem_wdata      = load_data;
        unique case (state_q)
            IDLE: begin
                if (load_en) begin
                    mem_we = 1'b1;
                end else if (!halted && bus.mem_req) begin
                    addr_d  = bus.mem_addr;
                    we_d    = bus.mem_write_en;
                    wdata_d = bus.mem_data_in;
                    cnt_d   = CNT_W'(DATA_LATENCY - 1);
                end else if (!halted && bus.fetch_req) begin
                    addr_d = bus.inst_addr;
                    cnt_d  = CNT_W'(FETCH_LATENCY - 1);
                end
            end
            FETCH_BUSY: begin
                if (!cnt_done) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    inst_valid_d = 1'b1;
                    mem_err_d    = !addr_ok;
                    inst_d       = addr_ok ? rd_data : 32'd0;
                end
            end
            DATA_BUSY: begin
                if (!cnt_done) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    mem_ack_d      = 1'b1;
                    mem_err_d      = !addr_ok;
                    mem_data_out_d = (addr_ok && !we_q) ? rd_data : 32'd0;
                    if (addr_ok && we_q) begin
                        mem_we    = 1'b1;
                        mem_waddr = idx;
                        mem_wdata = wdata_q;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q          <= '0;
            addr_q         <= '0;
            we_q           <= 1'b0;
            wdata_q        <= '0;
            inst_q         <= '0;
            inst_valid_q   <= 1'b0;
            mem_data_out_q <= '0;
            mem_ack_q      <= 1'b0;
            mem_err_q      <= 1'b0;
        end else begin
            cnt_q          <= cnt_d;
            addr_q         <= addr_d;
            we_q           <= we_d;
            wdata_q        <= wdata_d;
            inst_q         <= inst_d;
            inst_valid_q   <= inst_valid_d;
            mem_data_out_q <= mem_data_out_d;
            mem_ack_q      <= mem_ack_d;
            mem_err_q      <= mem_err_d;
        end
    end

    // Storage is not reset; reset only blocks a write in flight.
    always_ff @(posedge clk) begin
        if (mem_we && !rst) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    assign bus.inst         = inst_q;
    assign bus.inst_valid   = inst_valid_q;
    assign bus.mem_data_out = mem_data_out_q;
    assign bus.mem_ack      = mem_ack_q;
    assign bus.mem_err      = mem_err_q;

endmodule

// File: tb/tb_arm_mem_responder.sv
// Testbench for arm_mem_responder: directed scenarios plus random
// fetch/load/store/preload traffic checked against an array model.
module tb_arm_mem_responder;

    localparam int AW = 10;
    localparam int FL = 1;
    localparam int DL = 2;
    localparam int NWORDS = 64;

    logic          clk = 1'b0;
    logic          rst;
    logic          halted;
    logic          load_en;
    logic [AW-1:0] load_addr;
    logic [31:0]   load_data;

    arm_mem_responder_if bus();

    arm_mem_responder #(
        .ADDR_WIDTH   (AW),
        .FETCH_LATENCY(FL),
        .DATA_LATENCY (DL)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .halted   (halted),
        .load_en  (load_en),
        .load_addr(load_addr),
        .load_data(load_data),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    logic [31:0] model [1 << AW];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit bad_addr(input logic [31:0] a);
        return (a % 4 != 0) || (a >= (32'd4 << AW));
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input int idx, input logic [31:0] d);
        load_en   = 1'b1;
        load_addr = AW'(idx);
        load_data = d;
        tick();
        load_en = 1'b0;
        model[idx] = d;
    endtask

    task automatic wait_pulse(input bit is_fetch, output int n);
        bit hit;
        n = 0;
        hit = 1'b0;
        while (!hit && n < 20) begin
            tick();
            n++;
            hit = is_fetch ? bus.inst_valid : bus.mem_ack;
        end
    endtask

    task automatic xact(input string tag, input bit is_fetch, input bit we,
                        input logic [31:0] addr, input logic [31:0] wd);
        int n;
        int lat;
        bit e;
        logic [31:0] exp;
        lat = is_fetch ? FL : DL;
        e = bad_addr(addr);
        exp = (e || (!is_fetch && we)) ? 32'd0 : model[addr / 4];
        if (is_fetch) begin
            bus.fetch_req = 1'b1;
            bus.inst_addr = addr;
        end else begin
            bus.mem_req      = 1'b1;
            bus.mem_write_en = we;
            bus.mem_addr     = addr;
            bus.mem_data_in  = wd;
        end
        wait_pulse(is_fetch, n);
        bus.fetch_req = 1'b0;
        bus.mem_req   = 1'b0;
        check({tag, "/lat"}, n, lat + 1);
        check({tag, "/data"}, is_fetch ? bus.inst : bus.mem_data_out, exp);
        check({tag, "/err"}, {31'd0, bus.mem_err}, {31'd0, e});
        if (!is_fetch && we && !e) model[addr / 4] = wd;
        tick();
        check({tag, "/pulse_off"}, {31'd0, is_fetch ? bus.inst_valid : bus.mem_ack}, 32'd0);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "/inst"}, bus.inst, 32'd0);
        check({tag, "/inst_valid"}, {31'd0, bus.inst_valid}, 32'd0);
        check({tag, "/mem_data_out"}, bus.mem_data_out, 32'd0);
        check({tag, "/mem_ack"}, {31'd0, bus.mem_ack}, 32'd0);
        check({tag, "/mem_err"}, {31'd0, bus.mem_err}, 32'd0);
    endtask

    initial begin
        int n;
        rst = 1'b1;
        halted = 1'b0;
        load_en = 1'b0;
        load_addr = '0;
        load_data = '0;
        bus.fetch_req = 1'b0;
        bus.inst_addr = '0;
        bus.mem_req = 1'b0;
        bus.mem_write_en = 1'b0;
        bus.mem_addr = '0;
        bus.mem_data_in = '0;
        tick();
        tick();
        check_idle_outputs("reset");
        rst = 1'b0;

        for (int i = 0; i < NWORDS; i++) preload(i, $urandom);

        // Fetch of a preloaded instruction word
        preload(4, 32'hE3A01005);
        xact("fetch10", 1'b1, 1'b0, 32'h10, 32'd0);

        // Store then read-after-write
        xact("st40", 1'b0, 1'b1, 32'h40, 32'hDEADBEEF);
        xact("ld40", 1'b0, 1'b0, 32'h40, 32'd0);

        // Data beats fetch when both arrive together
        bus.fetch_req = 1'b1;
        bus.inst_addr = 32'h0;
        bus.mem_req = 1'b1;
        bus.mem_write_en = 1'b0;
        bus.mem_addr = 32'h8;
        wait_pulse(1'b0, n);
        bus.mem_req = 1'b0;
        check("both/ack_lat", n, DL + 1);
        check("both/no_inst", {31'd0, bus.inst_valid}, 32'd0);
        check("both/ld_data", bus.mem_data_out, model[2]);
        wait_pulse(1'b1, n);
        bus.fetch_req = 1'b0;
        check("both/fetch_lat", n, FL + 1);
        check("both/inst", bus.inst, model[0]);
        tick();

        // Error accesses
        xact("ld_mis", 1'b0, 1'b0, 32'h6, 32'd0);
        xact("ld_oor", 1'b0, 1'b0, 32'h1000, 32'd0);
        xact("st_oor", 1'b0, 1'b1, 32'h1000, 32'h12345678);
        xact("ld0_after_oor", 1'b0, 1'b0, 32'h0, 32'd0);

        // Reset one cycle before a store would commit
        bus.mem_req = 1'b1;
        bus.mem_write_en = 1'b1;
        bus.mem_addr = 32'h20;
        bus.mem_data_in = 32'hAAAA5555;
        tick();
        rst = 1'b1;
        bus.mem_req = 1'b0;
        tick();
        check_idle_outputs("midrst");
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("midrst/no_ack", {31'd0, bus.mem_ack}, 32'd0);
        end
        xact("ld20_old", 1'b0, 1'b0, 32'h20, 32'd0);

        // Halt blocks acceptance
        halted = 1'b1;
        bus.fetch_req = 1'b1;
        bus.inst_addr = 32'h10;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("halt/no_valid", {31'd0, bus.inst_valid}, 32'd0);
        end
        halted = 1'b0;
        wait_pulse(1'b1, n);
        bus.fetch_req = 1'b0;
        check("halt/lat", n, FL + 1);
        check("halt/inst", bus.inst, 32'hE3A01005);
        tick();

        // Preload collides with a request: preload wins, request waits one cycle
        load_en = 1'b1;
        load_addr = AW'(9);
        load_data = 32'hC0FFEE01;
        bus.mem_req = 1'b1;
        bus.mem_write_en = 1'b0;
        bus.mem_addr = 32'h24;
        tick();
        load_en = 1'b0;
        model[9] = 32'hC0FFEE01;
        wait_pulse(1'b0, n);
        bus.mem_req = 1'b0;
        check("coll/lat", n, DL + 1);
        check("coll/data", bus.mem_data_out, 32'hC0FFEE01);
        tick();

        // Random traffic
        for (int i = 0; i < 150; i++) begin
            int kind;
            int sel;
            logic [31:0] a;
            kind = $urandom_range(0, 9);
            sel = $urandom_range(0, 9);
            if (sel < 7) a = 32'($urandom_range(0, NWORDS - 1)) * 4;
            else if (sel == 7) a = 32'($urandom_range(0, NWORDS - 1)) * 4 + 32'($urandom_range(1, 3));
            else a = $urandom | (32'h1000 << $urandom_range(0, 19));
            if (kind < 4) xact("rnd_fetch", 1'b1, 1'b0, a, 32'd0);
            else if (kind < 7) xact("rnd_load", 1'b0, 1'b0, a, 32'd0);
            else if (kind < 9) xact("rnd_store", 1'b0, 1'b1, a, $urandom);
            else preload($urandom_range(0, NWORDS - 1), $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/arm_mem_responder.md
# arm_mem_responder

Memory-side responder for the ARM core's instruction-fetch and data load/store interfaces. It holds a word-addressed, single-ported storage array and serves one transaction at a time with a configurable per-port latency, a one-cycle completion pulse, and an error indication. It sits between the core's memory outputs (fetch address, data address, store data, write enable) and its memory inputs (instruction word, load data), and replaces the ideal zero-latency memory used in early bring-up.

## Interface
- ADDR_WIDTH, 10, log2 of storage depth in 32-bit words (1024 words by default).
- FETCH_LATENCY, 1, cycles from fetch acceptance to `inst_valid`; must be at least 1.
- DATA_LATENCY, 2, cycles from data-request acceptance to `mem_ack`; must be at least 1.

Ports:
- clk  input  1  clock.
- rst  input  1  reset, synchronous, active-high.
- halted  input  1  core halted; blocks acceptance of new fetch and data requests.
- fetch_req  input  1  fetch request; held high until `inst_valid`.
- inst_addr  input  32  byte address for the fetch.
- inst  output  32  fetched instruction word; valid while `inst_valid` is high.
- inst_valid  output  1  one-cycle fetch completion pulse.
- mem_req  input  1  data request; held high until `mem_ack`.
- mem_write_en  input  1  1 = store, 0 = load; sampled at acceptance.
- mem_addr  input  32  byte address for the load or store.
- mem_data_in  input  32  store data; sampled at acceptance.
- mem_data_out  output  32  load data; valid while `mem_ack` is high.
- mem_ack  output  1  one-cycle data completion pulse.
- mem_err  output  1  qualifies `inst_valid` or `mem_ack`; 1 = misaligned or out-of-range access.
- load_en  input  1  backdoor preload write strobe.
- load_addr  input  ADDR_WIDTH  word index for the preload.
- load_data  input  32  preload data.

## Operation
**States**
- IDLE: no transaction in flight.
- FETCH_BUSY: a fetch is in flight.
- DATA_BUSY: a data access is in flight.

**Acceptance (IDLE only, priority order)**
- `load_en` high: write `load_data` to `mem[load_addr]`. No request is accepted in that cycle.
- Otherwise, `mem_req` high and `halted` low: latch address, write enable and write data. Load the counter with DATA_LATENCY-1 and go to DATA_BUSY.
- Otherwise, `fetch_req` high and `halted` low: latch the address. Load the counter with FETCH_LATENCY-1 and go to FETCH_BUSY.
- Data requests take priority over fetches when both are present.

**BUSY states**
- While the counter is nonzero, decrement it.
- When the counter reaches 0, complete the access:
  - Assert the matching pulse (`inst_valid` or `mem_ack`) for one cycle.
  - Drive `mem_err` for that cycle.
  - Return to IDLE.
- New requests, `load_en` and `halted` are ignored while busy. An in-flight access always completes.

**Address check on the latched address**
- Error if addr[1:0] != 0 (misaligned).
- Error if addr[31:ADDR_WIDTH+2] != 0 (out of range).
- Otherwise the word index is addr[ADDR_WIDTH+1:2].

**Completion**
- Good load or fetch: the output carries `mem[index]` read at the completion cycle.
- Good store: `mem[index]` is written at the completion edge, and `mem_data_out` = 0.
- Error access: no storage write, the data output is 0, and `mem_err` = 1.

**Outputs between completions**
- `inst` and `mem_data_out` hold their last completion value.
- `inst_valid`, `mem_ack` and `mem_err` are 0.

## Timing
- Reset: state IDLE, counter 0, and all outputs 0 (`inst`, `inst_valid`, `mem_data_out`, `mem_ack`, `mem_err`). Storage contents are not changed by reset.
- Reset mid-transaction: the transaction is aborted and produces no pulse. A pending store is not committed.
- Latency: a request accepted at edge N completes with its pulse high during the cycle after edge N+LAT, where LAT = FETCH_LATENCY or DATA_LATENCY.
- Back-to-back requests: the next acceptance is possible at the edge on which the pulse cycle ends. The minimum spacing between acceptances is LAT+1 edges.
- Read-after-write: a load accepted after a store's `mem_ack` returns the stored value.
- Outputs are registered. There is no combinational path from any input to any output.
- Simultaneous events:
  - `load_en` together with a request in IDLE: the load wins and the request stays pending.
  - `halted` rising while busy: the current access finishes and nothing further is accepted.

## Test plan
- Preload `mem[4]` = 0xE3A01005, then fetch with `inst_addr` = 0x10 and FETCH_LATENCY = 1 -> `inst` = 0xE3A01005 and `inst_valid` high for exactly one cycle, 1 cycle after acceptance, with `mem_err` = 0.
- Store 0xDEADBEEF to 0x40, then load from 0x40 with DATA_LATENCY = 2 -> each `mem_ack` arrives 2 cycles after acceptance, and the load returns 0xDEADBEEF.
- Raise `fetch_req` (0x0) and `mem_req` (load 0x8) in the same IDLE cycle -> the data access completes first; the fetch is accepted at the edge after `mem_ack` and then completes.
- Load from 0x6 (misaligned) and from 0x1000 (out of range, ADDR_WIDTH = 10) -> `mem_ack` = 1 with `mem_err` = 1 and `mem_data_out` = 0; a store to 0x1000 leaves storage unchanged.
- Assert `rst` one cycle before a pending store to 0x20 would complete -> no `mem_ack`, all outputs 0, and a later load of 0x20 returns the old value.
- Hold `halted` = 1 with `fetch_req` high -> no `inst_valid` appears; dropping `halted` causes acceptance on the next edge.
